// File: rtl/nv_nvdla_glb_cacc_intr_pkg.sv
// Shared GLB constants: register offsets, interrupt group bit indices and interrupt width.
// No logic, so no latency or backpressure.
package nv_nvdla_glb_cacc_intr_pkg;
    localparam int INTR_W = 2;
    localparam int GRP0   = 0;
    localparam int GRP1   = 1;

    localparam logic [11:0] OFS_STATUS = 12'h000;
    localparam logic [11:0] OFS_MASK   = 12'h004;
    localparam logic [11:0] OFS_SET    = 12'h008;
    localparam logic [11:0] OFS_OVF    = 12'h00C;
endpackage

// File: rtl/nv_nvdla_glb_cacc_intr_if.sv
// Register access port of the CACC interrupt block; write strobe, offset and data in, read data out.
// Reads are combinational; writes take effect on the next edge; no backpressure.
interface nv_nvdla_glb_cacc_intr_if;
    logic        reg_wr_en;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data;

    modport master (output reg_wr_en, output reg_offset, output reg_wr_data, input reg_rd_data);
    modport slave  (input reg_wr_en, input reg_offset, input reg_wr_data, output reg_rd_data);
endinterface

// File: rtl/nv_nvdla_glb_intr_bit.sv
// One interrupt status bit (set-wins over W1C) plus optional saturating overflow counter (NVDLA_GLB_CACC_INTR_OVF_CNT_EN).
// Status and counter update one cycle after their inputs; no backpressure, every pulse is an event.
module nv_nvdla_glb_intr_bit #(
    parameter int OVF_CNT_W = 8
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 i_pulse,
    input  logic                 i_w1c,
    input  logic                 i_set,
`ifdef NVDLA_GLB_CACC_INTR_OVF_CNT_EN
    input  logic                 i_ovf_clr,
`endif
    output logic                 o_status,
    output logic [OVF_CNT_W-1:0] o_ovf_cnt
);
    logic r_status;

    // A new event always beats a software clear in the same cycle.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_status <= 1'b0;
        end else if (i_pulse || i_set) begin
            r_status <= 1'b1;
        end else if (i_w1c) begin
            r_status <= 1'b0;
        end
    end

    assign o_status = r_status;

`ifdef NVDLA_GLB_CACC_INTR_OVF_CNT_EN
    logic                 w_inc;
    logic [OVF_CNT_W-1:0] r_cnt;

    // Overflow = event lost because status was already pending and not being cleared.
    assign w_inc = i_pulse && r_status && !i_w1c;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_cnt <= '0;
        end else if (i_ovf_clr) begin
            r_cnt <= OVF_CNT_W'(w_inc);
        end else if (w_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + OVF_CNT_W'(1);
        end
    end

    assign o_ovf_cnt = r_cnt;
`else
    assign o_ovf_cnt = '0;
`endif
endmodule

// File: rtl/nv_nvdla_glb_cacc_intr.sv
// CACC done interrupt: STATUS/MASK/SET/OVF registers, level interrupt = registered |(STATUS & ~MASK); OVF per NVDLA_GLB_CACC_INTR_OVF_CNT_EN.
// Pulse -> STATUS next cycle -> interrupt the cycle after; no backpressure, reads combinational.
module nv_nvdla_glb_cacc_intr
    import nv_nvdla_glb_cacc_intr_pkg::*;
#(
    parameter int OVF_CNT_W = 8
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic [INTR_W-1:0]         cacc2glb_done_intr_pd,
    nv_nvdla_glb_cacc_intr_if.slave   reg_if,
    output logic                      cacc_done_intr
);
    logic                 w_sts_wr;
    logic                 w_mask_wr;
    logic                 w_set_wr;
    logic [INTR_W-1:0]    w_status;
    logic [OVF_CNT_W-1:0] w_cnt0;
    logic [OVF_CNT_W-1:0] w_cnt1;
    logic [INTR_W-1:0]    r_mask;
    logic                 r_intr;
    logic                 w_unused_wdat;

    assign w_sts_wr  = reg_if.reg_wr_en && (reg_if.reg_offset == OFS_STATUS);
    assign w_mask_wr = reg_if.reg_wr_en && (reg_if.reg_offset == OFS_MASK);
    assign w_set_wr  = reg_if.reg_wr_en && (reg_if.reg_offset == OFS_SET);
`ifdef NVDLA_GLB_CACC_INTR_OVF_CNT_EN
    logic w_ovf_wr;
    assign w_ovf_wr  = reg_if.reg_wr_en && (reg_if.reg_offset == OFS_OVF);
`endif
    assign w_unused_wdat = ^reg_if.reg_wr_data[31:INTR_W];

    nv_nvdla_glb_intr_bit #(.OVF_CNT_W(OVF_CNT_W)) u_bit0 (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .i_pulse         (cacc2glb_done_intr_pd[GRP0]),
        .i_w1c           (w_sts_wr && reg_if.reg_wr_data[GRP0]),
        .i_set           (w_set_wr && reg_if.reg_wr_data[GRP0]),
`ifdef NVDLA_GLB_CACC_INTR_OVF_CNT_EN
        .i_ovf_clr       (w_ovf_wr),
`endif
        .o_status        (w_status[GRP0]),
        .o_ovf_cnt       (w_cnt0)
    );

    nv_nvdla_glb_intr_bit #(.OVF_CNT_W(OVF_CNT_W)) u_bit1 (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .i_pulse         (cacc2glb_done_intr_pd[GRP1]),
        .i_w1c           (w_sts_wr && reg_if.reg_wr_data[GRP1]),
        .i_set           (w_set_wr && reg_if.reg_wr_data[GRP1]),
`ifdef NVDLA_GLB_CACC_INTR_OVF_CNT_EN
        .i_ovf_clr       (w_ovf_wr),
`endif
        .o_status        (w_status[GRP1]),
        .o_ovf_cnt       (w_cnt1)
    );

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_mask <= '0;
            r_intr <= 1'b0;
        end else begin
            if (w_mask_wr) begin
                r_mask <= reg_if.reg_wr_data[INTR_W-1:0];
            end
            r_intr <= |(w_status & ~r_mask);
        end
    end

    assign cacc_done_intr = r_intr;

    // SET is write-only; without the counter option the OVF counters are constant zero.
    always_comb begin
        reg_if.reg_rd_data = '0;
        case (reg_if.reg_offset)
            OFS_STATUS: reg_if.reg_rd_data = 32'(w_status);
            OFS_MASK:   reg_if.reg_rd_data = 32'(r_mask);
            OFS_OVF:    reg_if.reg_rd_data = 32'({w_cnt1, w_cnt0});
            default:    reg_if.reg_rd_data = '0;
        endcase
    end
endmodule

// File: tb/tb_nv_nvdla_glb_cacc_intr.sv
// Directed, table-driven check of the CACC interrupt block, plus hand sequences for reset and overflow.
module tb_nv_nvdla_glb_cacc_intr;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] pd = 2'b00;
    logic       intr;
    int         n_chk = 0;
    int         n_fail = 0;

    nv_nvdla_glb_cacc_intr_if bus ();

    nv_nvdla_glb_cacc_intr #(.OVF_CNT_W(8)) dut (
        .nvdla_core_clk        (clk),
        .nvdla_core_rstn       (rstn),
        .cacc2glb_done_intr_pd (pd),
        .reg_if                (bus),
        .cacc_done_intr        (intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pd;
        logic        we;
        logic [11:0] ofs;
        logic [31:0] wd;
        logic [1:0]  sts;
        logic        intr;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(logic [1:0] p, logic w, logic [11:0] o, logic [31:0] d,
                                logic [1:0] s, logic i);
        vec_t v;
        v.pd = p; v.we = w; v.ofs = o; v.wd = d; v.sts = s; v.intr = i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.reg_wr_en   = 1'b0;
        bus.reg_offset  = 12'h000;
        bus.reg_wr_data = 32'h0;
    endtask

    task automatic rd(input logic [11:0] ofs, output logic [31:0] d);
        bus.reg_wr_en  = 1'b0;
        bus.reg_offset = ofs;
        #1;
        d = bus.reg_rd_data;
    endtask

    task automatic wr(input logic [11:0] ofs, input logic [31:0] d, input logic [1:0] p);
        bus.reg_wr_en   = 1'b1;
        bus.reg_offset  = ofs;
        bus.reg_wr_data = d;
        pd              = p;
        tick();
        idle_bus();
        pd = 2'b00;
    endtask

    initial begin
        logic [31:0] d;
        idle_bus();

        vt[0]  = mk(2'b01, 1'b0, 12'h000, 32'h0,         2'b01, 1'b0);
        vt[1]  = mk(2'b00, 1'b0, 12'h000, 32'h0,         2'b01, 1'b1);
        vt[2]  = mk(2'b10, 1'b0, 12'h000, 32'h0,         2'b11, 1'b1);
        vt[3]  = mk(2'b00, 1'b1, 12'h000, 32'h1,         2'b10, 1'b1);
        vt[4]  = mk(2'b00, 1'b1, 12'h000, 32'h2,         2'b00, 1'b1);
        vt[5]  = mk(2'b00, 1'b0, 12'h000, 32'h0,         2'b00, 1'b0);
        vt[6]  = mk(2'b00, 1'b1, 12'h004, 32'h1,         2'b00, 1'b0);
        vt[7]  = mk(2'b01, 1'b0, 12'h000, 32'h0,         2'b01, 1'b0);
        vt[8]  = mk(2'b00, 1'b0, 12'h000, 32'h0,         2'b01, 1'b0);
        vt[9]  = mk(2'b00, 1'b1, 12'h004, 32'h0,         2'b01, 1'b0);
        vt[10] = mk(2'b00, 1'b0, 12'h000, 32'h0,         2'b01, 1'b1);
        vt[11] = mk(2'b01, 1'b1, 12'h000, 32'h1,         2'b01, 1'b1);
        vt[12] = mk(2'b00, 1'b1, 12'h000, 32'h3,         2'b00, 1'b1);
        vt[13] = mk(2'b11, 1'b0, 12'h000, 32'h0,         2'b11, 1'b0);
        vt[14] = mk(2'b00, 1'b1, 12'h000, 32'h3,         2'b00, 1'b1);
        vt[15] = mk(2'b10, 1'b1, 12'h008, 32'h2,         2'b10, 1'b0);
        vt[16] = mk(2'b00, 1'b1, 12'h008, 32'h1,         2'b11, 1'b1);
        vt[17] = mk(2'b00, 1'b1, 12'h010, 32'h3,         2'b11, 1'b1);
        vt[18] = mk(2'b00, 1'b1, 12'h000, 32'h0,         2'b11, 1'b1);
        vt[19] = mk(2'b00, 1'b1, 12'h004, 32'hFFFF_FFFF, 2'b11, 1'b1);
        vt[20] = mk(2'b00, 1'b0, 12'h000, 32'h0,         2'b11, 1'b0);

        // Reset state, asserted asynchronously at time zero
        #1;
        chk("reset_intr", {31'h0, intr}, 32'h0);
        rd(12'h000, d); chk("reset_status", d, 32'h0);
        rd(12'h004, d); chk("reset_mask", d, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 21; i++) begin
            bus.reg_wr_en   = vt[i].we;
            bus.reg_offset  = vt[i].ofs;
            bus.reg_wr_data = vt[i].wd;
            pd              = vt[i].pd;
            tick();
            pd = 2'b00;
            rd(12'h000, d);
            chk($sformatf("vec%0d_status", i), d, {30'h0, vt[i].sts});
            chk($sformatf("vec%0d_intr", i), {31'h0, intr}, {31'h0, vt[i].intr});
        end

        rd(12'h004, d); chk("mask_upper_zero", d, 32'h3);
        rd(12'h008, d); chk("set_reads_zero", d, 32'h0);
        rd(12'h010, d); chk("unmapped_reads_zero", d, 32'h0);
        rd(12'h00C, d); chk("ovf_no_count_on_w1c_collision", d, 32'h0);

        wr(12'h004, 32'h0, 2'b00);
        wr(12'h000, 32'h3, 2'b00);
        tick();
        rd(12'h000, d); chk("cleanup_status", d, 32'h0);
        chk("cleanup_intr", {31'h0, intr}, 32'h0);

        // Held-high input: three cycles on bit0 are three events
        pd = 2'b01;
        repeat (3) tick();
        pd = 2'b00;
        rd(12'h000, d); chk("held_status", d, 32'h1);
`ifdef NVDLA_GLB_CACC_INTR_OVF_CNT_EN
        rd(12'h00C, d); chk("held_ovf_cnt0", d, 32'h0000_0002);
        wr(12'h00C, 32'h0, 2'b00);
        rd(12'h00C, d); chk("ovf_clear", d, 32'h0);

        wr(12'h008, 32'h2, 2'b00);
        pd = 2'b10;
        repeat (300) tick();
        pd = 2'b00;
        rd(12'h00C, d); chk("ovf_saturate", d, 32'h0000_FF00);
        wr(12'h00C, 32'h0, 2'b10);
        rd(12'h00C, d); chk("ovf_clear_with_inc", d, 32'h0000_0100);
        wr(12'h00C, 32'h0, 2'b00);
        rd(12'h00C, d); chk("ovf_clear_again", d, 32'h0);
`else
        rd(12'h00C, d); chk("ovf_absent_reads_zero", d, 32'h0);
`endif
        wr(12'h000, 32'h3, 2'b00);

        // Asynchronous reset in the middle of a continuous pulse train
        wr(12'h004, 32'h1, 2'b00);
        pd = 2'b10;
        repeat (3) tick();
        rd(12'h000, d); chk("pre_reset_status", d, 32'h2);
        chk("pre_reset_intr", {31'h0, intr}, 32'h1);
        #3;
        rstn = 1'b0;
        #1;
        chk("async_reset_intr", {31'h0, intr}, 32'h0);
        rd(12'h000, d); chk("async_reset_status", d, 32'h0);
        rd(12'h004, d); chk("async_reset_mask", d, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rd(12'h000, d); chk("pulses_ignored_in_reset", d, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        rd(12'h000, d); chk("first_edge_after_release", d, 32'h2);
        pd = 2'b00;
        tick();
        chk("intr_after_release", {31'h0, intr}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nv_nvdla_glb_cacc_intr.md
NV_NVDLA_GLB_CACC_INTR -- requirements
Module: NV_NVDLA_GLB_cacc_intr

Interface
REQ-001 Parameter: OVF_CNT_W, default 8, width of the per-bit overflow counters.
REQ-002 Port: nvdla_core_clk  in  1  sole clock; all state SHALL be on its rising edge.
REQ-003 Port: nvdla_core_rstn  in  1  reset; SHALL be asynchronous and active-low.
REQ-004 Port: cacc2glb_done_intr_pd  in  2  retimed CACC done pulses; bit0 = group 0, bit1 = group 1; each is a one-cycle pulse per event.
REQ-005 Port: reg_wr_en  in  1  register write strobe, one cycle per write.
REQ-006 Port: reg_offset  in  12  byte offset of the register access.
REQ-007 Port: reg_wr_data  in  32  write data.
REQ-008 Port: reg_rd_data  out  32  read data, combinational from reg_offset.
REQ-009 Port: cacc_done_intr  out  1  registered, level-sensitive interrupt to the core interrupt tree.

Function
REQ-010 Register map: 0x000 STATUS[1:0] (read; W1C), 0x004 MASK[1:0] (RW, 1 = masked), 0x008 SET[1:0] (write-only, write-1 sets STATUS, reads 0), 0x00C OVF (read-only, present only per REQ-024); unmapped offsets SHALL read 0 and ignore writes.
REQ-011 Unused upper bits of every register SHALL read 0.
REQ-012 A pulse on cacc2glb_done_intr_pd[i] in cycle N SHALL set STATUS[i], visible in cycle N+1.
REQ-013 A STATUS write with reg_wr_data[i]=1 in cycle N SHALL clear STATUS[i] in cycle N+1; a data bit of 0 SHALL leave the bit unchanged.
REQ-014 A hardware pulse and a W1C on the same bit in the same cycle SHALL leave STATUS[i]=1, so the set wins.
REQ-015 A SET write and a W1C cannot coincide (single write port); a SET write and a hardware pulse on the same bit SHALL result in STATUS[i]=1.
REQ-016 MASK SHALL NOT gate STATUS updates; masked events still set STATUS.
REQ-017 cacc_done_intr SHALL be registered as |(STATUS & ~MASK) and lag STATUS by one cycle; a pulse in cycle N SHALL raise the interrupt in cycle N+2.
REQ-018 Clearing the last unmasked STATUS bit, or masking it, in cycle N SHALL drop cacc_done_intr in cycle N+2.
REQ-019 Both input bits pulsing in the same cycle SHALL set both STATUS bits, with no loss.
REQ-020 Input bits held high for several cycles SHALL be treated as repeated pulses, one event per cycle.

Reset
REQ-021 On nvdla_core_rstn low: STATUS = 2'b00, MASK = 2'b00, overflow counters = 0, cacc_done_intr = 0, all immediately and asynchronously.
REQ-022 Reset asserted mid-operation SHALL discard pending status; pulses arriving while reset is low SHALL be ignored.
REQ-023 Release SHALL be synchronous to nvdla_core_clk; the first event SHALL be captured on the first rising edge after release.

Configuration
REQ-024 Macro NVDLA_GLB_CACC_INTR_OVF_CNT_EN: when defined, each bit i SHALL have a saturating OVF_CNT_W-bit counter that increments when a pulse arrives while STATUS[i]=1 and no W1C of bit i occurs in the same cycle.
REQ-025 With the macro, OVF reads as {cnt1 at [15:8], cnt0 at [7:0]} (for OVF_CNT_W=8), saturates at all-ones, and any write to 0x00C clears both counters; a write and an increment in the same cycle SHALL leave the counter at 1.
REQ-026 Without the macro, no counter flops SHALL exist and 0x00C SHALL read 0.

Structure
REQ-027 Register offsets, the bit-index constants GRP0/GRP1 and the interrupt width (2) SHALL live in the shared GLB package.
REQ-028 The per-bit status/overflow slice SHALL be one sub-module, NV_NVDLA_GLB_intr_bit, instantiated twice.

Verification
REQ-029 Pulse bit0 at cycle 10 with MASK=0 -> STATUS=0x1 at cycle 11, cacc_done_intr=1 at cycle 12.
REQ-030 STATUS=0x3, write 0x000 data 0x1 -> STATUS=0x2 the next cycle, cacc_done_intr stays 1; then write 0x2 -> STATUS=0, interrupt drops 2 cycles after the write.
REQ-031 MASK=0x1, pulse bit0 -> STATUS=0x1, cacc_done_intr stays 0; write MASK=0 -> interrupt=1 two cycles later.
REQ-032 STATUS=0x1, pulse bit0 in the same cycle as a W1C of bit0 -> STATUS remains 0x1, OVF cnt0 unchanged.
REQ-033 With the macro: STATUS[1]=1, then 300 pulses on bit1 -> OVF reads 0x0000FF00; write 0x00C -> reads 0.
REQ-034 Pulse bit1 continuously, assert nvdla_core_rstn low mid-cycle -> all outputs 0 immediately; after release, the next pulse sets STATUS=0x2.
